// File: rtl/im_boot_loader.sv
// -----------------------------------------------------------------------------
// im_boot_loader
//
// Owns the instruction-memory port while a program image is streamed in from
// an external source. The PC stays stalled for the whole load. After the last
// word is written, the PC receives a one-cycle branch to the base address, and
// the IM address port is handed back to the fetch path.
//
// Optional feature (compile-time macro IMBOOT_CHECKSUM_EN):
//   When the macro is defined, the source sends one extra word after the
//   image. That word must equal the mod-2^16 sum of all image words.
//   - On a match, the loader branches to the base address as usual.
//   - On a mismatch, the loader sets the sticky error flag and returns to
//     idle with no branch and no done pulse.
//   When the macro is undefined, error is tied to 0.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   start          one-cycle load request (sampled in IDLE only)
//   length         number of words to load, 0..2^ADDR_W
//   base_address   first IM write address and PC restart address
//   s_valid/s_data source word stream; s_ready = loader accepts a word
//   pc_address     fetch address from the PC
//   im_address     address to IM (pc_address when not loading)
//   im_data_in     write data to IM
//   im_en_write    IM write enable
//   cpu_stall      PC stall
//   cpu_branch     PC branch (one cycle, in RELEASE)
//   cpu_br_address PC branch target (0 when cpu_branch is 0)
//   busy           load in progress
//   done           one-cycle pulse when a load completes
//   error          sticky checksum failure
// -----------------------------------------------------------------------------
module im_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [ADDR_W-1:0] base_address,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] pc_address,
    output logic [ADDR_W-1:0] im_address,
    output logic [DATA_W-1:0] im_data_in,
    output logic              im_en_write,
    output logic              cpu_stall,
    output logic              cpu_branch,
    output logic [ADDR_W-1:0] cpu_br_address,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef IMBOOT_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_CHECK   = 2'b11
    } state_t;

    // After the last image word, the checksum word is still outstanding.
    localparam state_t ST_AFTER_LOAD = ST_CHECK;

    // Running sum of the image, modulo 2^DATA_W (16 bits at the default width).
    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
        return acc + word;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam state_t ST_AFTER_LOAD = ST_RELEASE;
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   remaining_r;
    logic [ADDR_W-1:0] base_r;
    logic              done_r;
    logic              handshake_s;

`ifdef IMBOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_r;
    logic              error_r;
`endif

    assign handshake_s = s_valid & s_ready;
    assign done        = done_r;

`ifdef IMBOOT_CHECKSUM_EN
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and IM/PC port steering.
    always_comb begin
        state_nxt_s    = state_r;
        s_ready        = 1'b0;
        im_address     = pc_address;
        im_data_in     = {DATA_W{1'b0}};
        im_en_write    = 1'b0;
        cpu_stall      = 1'b0;
        cpu_branch     = 1'b0;
        cpu_br_address = {ADDR_W{1'b0}};
        busy           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A zero-length start only produces a done pulse and never leaves IDLE.
                if (start && (length != LEN_ZERO)) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                s_ready     = 1'b1;
                cpu_stall   = 1'b1;
                busy        = 1'b1;
                im_address  = wr_ptr_r;
                im_data_in  = s_data;
                im_en_write = s_valid;
                if (s_valid && (remaining_r == LEN_ONE)) begin
                    state_nxt_s = ST_AFTER_LOAD;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
`ifdef IMBOOT_CHECKSUM_EN
            ST_CHECK: begin
                // The checksum word is consumed but never written to IM.
                s_ready   = 1'b1;
                cpu_stall = 1'b1;
                busy      = 1'b1;
                if (s_valid) begin
                    if (s_data == sum_r) begin
                        state_nxt_s = ST_RELEASE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
`endif
            ST_RELEASE: begin
                cpu_stall      = 1'b1;
                cpu_branch     = 1'b1;
                cpu_br_address = base_r;
                busy           = 1'b1;
                state_nxt_s    = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Load pointers, base register and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= {ADDR_W{1'b0}};
            remaining_r <= LEN_ZERO;
            base_r      <= {ADDR_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (length != LEN_ZERO) begin
                            wr_ptr_r    <= base_address;
                            base_r      <= base_address;
                            remaining_r <= length;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Wrapping from the top of IM back to 0 is intentional.
                    if (handshake_s) begin
                        wr_ptr_r    <= wr_ptr_r + ADDR_ONE;
                        remaining_r <= remaining_r - LEN_ONE;
                    end
                end
                ST_RELEASE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMBOOT_CHECKSUM_EN
    // Image checksum accumulator and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r   <= {DATA_W{1'b0}};
            error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sum_r   <= {DATA_W{1'b0}};
                        error_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (handshake_s) begin
                        sum_r <= csum_add(sum_r, s_data);
                    end
                end
                ST_CHECK: begin
                    if (handshake_s && (s_data != sum_r)) begin
                        error_r <= 1'b1;
                    end
                end
                default: begin
                    error_r <= error_r;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_im_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_im_boot_loader
//
// Directed bench for im_boot_loader. It includes a behavioural IM that
// captures writes on the rising edge. The bench plays the PC itself:
// after a RELEASE cycle it moves pc_address to the branch target. Inputs
// are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_im_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] length;
    logic [9:0]  base_address;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [9:0]  pc_address;
    logic [9:0]  im_address;
    logic [15:0] im_data_in;
    logic        im_en_write;
    logic        cpu_stall;
    logic        cpu_branch;
    logic [9:0]  cpu_br_address;
    logic        busy;
    logic        done;
    logic        error;

    logic [15:0] mem [0:1023];
    logic [15:0] words [0:3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    im_boot_loader #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .length        (length),
        .base_address  (base_address),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .pc_address    (pc_address),
        .im_address    (im_address),
        .im_data_in    (im_data_in),
        .im_en_write   (im_en_write),
        .cpu_stall     (cpu_stall),
        .cpu_branch    (cpu_branch),
        .cpu_br_address(cpu_br_address),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    // Behavioural instruction memory.
    always @(posedge clk) begin
        if (im_en_write) begin
            mem[im_address] <= im_data_in;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full load of len words from words[], optionally gapped, optionally with
    // a stray start pulse during the first word.
    task automatic run_load(input logic [9:0] base, input int len, input logic gapped, input logic poke);
        int          load_cycles;
        logic [9:0]  addr;
`ifdef IMBOOT_CHECKSUM_EN
        logic [15:0] sum;
        sum = 16'h0000;
`endif
        load_cycles = 0;
        @(posedge clk); #1;
        start = 1'b1; length = 11'(len); base_address = base;
        @(negedge clk);
        check_value("idle_no_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; length = 11'd0; base_address = 10'd0;
        addr = base;
        for (int i = 0; i < len; i++) begin
            if (gapped) begin
                s_valid = 1'b0;
                @(negedge clk);
                if (cpu_stall && s_ready) load_cycles++;
                check_value("gap_stall", 32'(cpu_stall), 32'd1);
                check_value("gap_no_write", 32'(im_en_write), 32'd0);
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = words[i];
            if (poke && (i == 0)) begin
                start = 1'b1; length = 11'd0; base_address = 10'h200;
            end
            @(negedge clk);
            if (cpu_stall && s_ready) load_cycles++;
            check_value("load_addr", 32'(im_address), 32'(addr));
            check_value("load_wen", 32'(im_en_write), 32'd1);
            check_value("load_wdata", 32'(im_data_in), 32'(words[i]));
            check_value("load_busy", 32'(busy), 32'd1);
            check_value("load_no_done", 32'(done), 32'd0);
`ifdef IMBOOT_CHECKSUM_EN
            sum = sum + words[i];
`endif
            @(posedge clk); #1;
            start = 1'b0; length = 11'd0; base_address = 10'd0;
            addr = addr + 10'd1;
        end
`ifdef IMBOOT_CHECKSUM_EN
        s_valid = 1'b1;
        s_data  = sum;
        @(negedge clk);
        check_value("check_ready", 32'(s_ready), 32'd1);
        check_value("check_no_write", 32'(im_en_write), 32'd0);
        check_value("check_stall", 32'(cpu_stall), 32'd1);
        @(posedge clk); #1;
`endif
        s_valid = 1'b0;
        @(negedge clk);
        check_value("rel_branch", 32'(cpu_branch), 32'd1);
        check_value("rel_br_addr", 32'(cpu_br_address), 32'(base));
        check_value("rel_stall", 32'(cpu_stall), 32'd1);
        check_value("rel_ready", 32'(s_ready), 32'd0);
        check_value("rel_im_addr", 32'(im_address), 32'(pc_address));
        check_value("rel_error", 32'(error), 32'd0);
        @(posedge clk); #1;
        pc_address = base;
        @(negedge clk);
        check_value("done_pulse", 32'(done), 32'd1);
        check_value("done_no_stall", 32'(cpu_stall), 32'd0);
        check_value("done_no_branch", 32'(cpu_branch), 32'd0);
        check_value("done_br_zero", 32'(cpu_br_address), 32'd0);
        check_value("fetch_word", 32'(mem[im_address]), 32'(words[0]));
        @(posedge clk); #1;
        @(negedge clk);
        check_value("done_one_cycle", 32'(done), 32'd0);
        check_value("load_cycles", 32'(load_cycles), gapped ? 32'(2 * len) : 32'(len));
        for (int i = 0; i < len; i++) begin
            addr = base + 10'(i);
            check_value("im_contents", 32'(mem[addr]), 32'(words[i]));
        end
    endtask

`ifdef IMBOOT_CHECKSUM_EN
    // Two words followed by a wrong checksum word.
    task automatic run_bad_sum();
        @(posedge clk); #1;
        start = 1'b1; length = 11'd2; base_address = 10'h020;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1; s_data = 16'h0011;
        @(posedge clk); #1;
        s_data = 16'h0022;
        @(posedge clk); #1;
        s_data = 16'h0034;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check_value("bad_sum_error", 32'(error), 32'd1);
        check_value("bad_sum_no_branch", 32'(cpu_branch), 32'd0);
        check_value("bad_sum_no_stall", 32'(cpu_stall), 32'd0);
        check_value("bad_sum_no_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_value("bad_sum_no_done2", 32'(done), 32'd0);
        check_value("bad_sum_sticky", 32'(error), 32'd1);
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; length = 11'd0; base_address = 10'd0;
        s_valid = 1'b0; s_data = 16'h0000; pc_address = 10'h155;

        // Reset state.
        #2;
        check_value("rst_im_addr", 32'(im_address), 32'h155);
        check_value("rst_stall", 32'(cpu_stall), 32'd0);
        check_value("rst_ready", 32'(s_ready), 32'd0);
        check_value("rst_branch", 32'(cpu_branch), 32'd0);
        check_value("rst_br_addr", 32'(cpu_br_address), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_error", 32'(error), 32'd0);
        check_value("rst_wen", 32'(im_en_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back load of 4 words.
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;
        run_load(10'h000, 4, 1'b0, 1'b0);

        // Same load, gapped source.
        run_load(10'h000, 4, 1'b1, 1'b0);

        // Zero-length start.
        @(posedge clk); #1;
        start = 1'b1; length = 11'd0; base_address = 10'h0AA;
        @(negedge clk);
        check_value("zl_no_stall", 32'(cpu_stall), 32'd0);
        check_value("zl_no_done_yet", 32'(done), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_value("zl_done", 32'(done), 32'd1);
        check_value("zl_stall", 32'(cpu_stall), 32'd0);
        check_value("zl_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_value("zl_done_once", 32'(done), 32'd0);

        // Stray start during LOAD is ignored.
        words[0] = 16'h0A0A; words[1] = 16'h0B0B;
        run_load(10'h010, 2, 1'b0, 1'b1);

        // Reset after 2 of 4 words.
        pc_address = 10'h2A5;
        @(posedge clk); #1;
        start = 1'b1; length = 11'd4; base_address = 10'h000;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 16'h1111;
        @(posedge clk); #1;
        s_data = 16'h2222;
        @(posedge clk); #1;
        s_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_value("mid_rst_stall", 32'(cpu_stall), 32'd0);
        check_value("mid_rst_busy", 32'(busy), 32'd0);
        check_value("mid_rst_ready", 32'(s_ready), 32'd0);
        check_value("mid_rst_im_addr", 32'(im_address), 32'h2A5);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("mid_rst_no_done", 32'(done), 32'd0);
            check_value("mid_rst_no_branch", 32'(cpu_branch), 32'd0);
        end
        check_value("mid_rst_im0", 32'(mem[0]), 32'h1111);
        check_value("mid_rst_im1", 32'(mem[1]), 32'h2222);
        check_value("mid_rst_im2", 32'(mem[2]), 32'h0033);
        check_value("mid_rst_im3", 32'(mem[3]), 32'h0044);

        // Address wrap at the top of IM.
        words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003; words[3] = 16'hA004;
        run_load(10'h3FE, 4, 1'b0, 1'b0);
        check_value("wrap_im0", 32'(mem[0]), 32'hA003);
        check_value("wrap_im1", 32'(mem[1]), 32'hA004);

`ifdef IMBOOT_CHECKSUM_EN
        run_bad_sum();
        // A good load afterwards clears the error (checked inside run_load).
        words[0] = 16'h0011; words[1] = 16'h0022;
        run_load(10'h020, 2, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Controller that owns the instruction-memory write/read port.
- Streams a program image (16-bit words, valid/ready) into IM at a programmed base address while holding the PC stalled.
- After the load, redirects the PC to the base address via a one-cycle branch and hands the IM address port back to the fetch path.
- Sits between PC, IM and the external program source (test bench or debug link).

Parameters:
- ADDR_W, 10, IM address width (IM depth = 2^ADDR_W words)
- DATA_W, 16, instruction word width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- length  input  ADDR_W+1  number of words to load, 0..2^ADDR_W; sampled with start
- base_address  input  ADDR_W  first IM address to write and PC restart address; sampled with start
- s_valid  input  1  source word valid
- s_data  input  DATA_W  source word
- s_ready  output  1  loader accepts word this cycle
- pc_address  input  ADDR_W  fetch address from PC (instr_address)
- im_address  output  ADDR_W  address to IM
- im_data_in  output  DATA_W  write data to IM
- im_en_write  output  1  IM write enable
- cpu_stall  output  1  to PC stall
- cpu_branch  output  1  to PC branch
- cpu_br_address  output  ADDR_W  to PC br_address
- busy  output  1  high in LOAD and RELEASE
- done  output  1  one-cycle pulse when the load completes
- error  output  1  sticky checksum failure (0 when feature absent)

Behaviour:
- States: IDLE, LOAD, RELEASE (plus CHECK with the optional feature). Registered state, 2-bit encoding.
- Reset (reset=0, asynchronous):
  - state=IDLE; wr_ptr=0, remaining=0, base register=0, error=0.
  - All outputs 0 except im_address=pc_address.
- IDLE:
  - s_ready=0, im_en_write=0, cpu_stall=0, cpu_branch=0.
  - im_address=pc_address (combinational pass-through, zero added latency on fetch).
  - start=1 and length!=0: capture base_address into wr_ptr and the base register, capture length into remaining, go to LOAD next edge.
  - start=1 and length==0: no state change; done pulses the next cycle.
- LOAD:
  - cpu_stall=1, busy=1, s_ready=1.
  - im_address=wr_ptr, im_data_in=s_data, im_en_write=s_valid (combinational). IM captures the word on the same edge the handshake completes.
  - On handshake (s_valid & s_ready): wr_ptr=wr_ptr+1 mod 2^ADDR_W, remaining=remaining-1.
  - The wr_ptr wrap from 2^ADDR_W-1 to 0 is legal and unflagged.
  - s_valid=0: no write, counters hold, stall persists indefinitely.
  - Handshake with remaining==1: go to RELEASE (or CHECK).
  - start is ignored while in LOAD.
- RELEASE (exactly 1 cycle):
  - cpu_stall=1, cpu_branch=1, cpu_br_address=base register, im_address=pc_address, s_ready=0, im_en_write=0.
  - The PC loads the base on this edge.
  - Next state IDLE; done=1 during the first IDLE cycle.
- cpu_br_address=0 whenever cpu_branch=0.
- Reset mid-LOAD: abort immediately, stall drops, no branch, no done. Words already written stay in IM.
- Fetch during LOAD: PC is held, so no arbitration conflict. The loader has absolute priority on the IM port.

Optional Feature:
- Macro: IMBOOT_CHECKSUM_EN
- Defined:
  - A 16-bit running sum (mod 2^16) accumulates each accepted word; cleared on start.
  - After the last data word, state CHECK: s_ready=1, im_en_write=0, cpu_stall=1. The next accepted word is compared with the sum.
  - Match: go to RELEASE.
  - Mismatch: error=1 (sticky until reset or the next start), go to IDLE without branch or done. The PC is unstalled but not redirected.
- Undefined: no CHECK state, no accumulator, error tied to 0.

Test Plan:
- Load 4 words: base=0x000, length=4, words 0x0011,0x0022,0x0033,0x0044 back-to-back.
  - Expect s_ready high 4 cycles, IM[0..3] written, RELEASE with cpu_branch=1 and cpu_br_address=0x000.
  - Then done pulse, PC fetches 0x0011.
- Gapped source: same load with s_valid low on alternate cycles.
  - Expect 8 cycles in LOAD, cpu_stall=1 throughout, identical IM contents.
- Wrap: base=0x3FE, length=4.
  - Expect writes to 0x3FE, 0x3FF, 0x000, 0x001, then branch to 0x3FE.
- Corner cases: start with length=0 gives done after 1 cycle, no stall. A start pulse during LOAD is ignored.
- Reset mid-load: assert reset after 2 of 4 words.
  - Expect immediate IDLE, stall=0, no done. IM[0..1] hold new data, IM[2..3] unchanged.
- With IMBOOT_CHECKSUM_EN, words 0x0011,0x0022 then 0x0033 → branch and done. Same words then 0x0034 → error=1, no branch.
